// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller: SR/Cause/EPC/PRId registers and a
// four-state trap/return sequencer driving one-cycle redirect pulses.
module exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  ExcCode_M,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic        ERET_M,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        Interrupt,
  output logic        ERET,
  output logic [31:0] EPC,
  output logic        flush
);

  typedef enum logic [1:0] {RUN, TRAP, HANDLER, RETURN} state_t;

  localparam logic [31:0] PRID = 32'h2019_0305;

  state_t      state, state_nxt;
  logic [5:0]  im, ip;
  logic        exl, ie, bd;
  logic [4:0]  exccode;
  logic [31:0] epc;
  logic        int_req, exc_req, trap_go, ret_go;
  logic        unused_wdata;

  // Restart address of the faulting instruction; a delay-slot victim restarts at its branch.
  function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic in_slot);
    logic [31:0] v;
    v = in_slot ? pc - 32'd4 : pc;
    return {v[31:2], 2'b00};
  endfunction

  assign unused_wdata = ^{cp0_wdata[31:16], cp0_wdata[9:2]};

  always_comb begin
    int_req = (|(HWInt & im)) & ie & ~exl;
    exc_req = (ExcCode_M != 5'd0) & ~exl;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trap_go   = 1'b0;
    ret_go    = 1'b0;
    case (state)
      RUN: begin
        if (int_req || exc_req) begin
          state_nxt = TRAP;
          trap_go   = 1'b1;
        end else if (ERET_M) begin
          state_nxt = RETURN;
          ret_go    = 1'b1;
        end
      end
      TRAP:    state_nxt = HANDLER;
      HANDLER: begin
        if (ERET_M) begin
          state_nxt = RETURN;
          ret_go    = 1'b1;
        end
      end
      RETURN:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    Interrupt = (state == TRAP);
    ERET      = (state == RETURN);
    flush     = (state == TRAP) || (state == RETURN);
  end

  // MTC0 is dropped whenever the sequencer redirects, since that instruction is flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      ip      <= '0;
      bd      <= 1'b0;
      exccode <= '0;
      epc     <= '0;
    end else begin
      ip <= HWInt;
      if (trap_go) begin
        exl     <= 1'b1;
        bd      <= BD_M;
        exccode <= int_req ? 5'd0 : ExcCode_M;
        epc     <= restart_pc(PC_M, BD_M);
      end else if (ret_go) begin
        exl <= 1'b0;
      end else if (cp0_we) begin
        case (cp0_addr)
          5'd12: begin
            im  <= cp0_wdata[15:10];
            exl <= cp0_wdata[1];
            ie  <= cp0_wdata[0];
          end
          5'd14:   epc <= {cp0_wdata[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      5'd12:   cp0_rdata = {16'd0, im, 8'd0, exl, ie};
      5'd13:   cp0_rdata = {bd, 15'd0, ip, 3'd0, exccode, 2'b00};
      5'd14:   cp0_rdata = epc;
      5'd15:   cp0_rdata = PRID;
      default: cp0_rdata = 32'd0;
    endcase
  end

  assign EPC = epc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random traffic, all checked
// against a behavioural CP0 model kept in the bench.
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  HWInt;
  logic [4:0]  ExcCode_M;
  logic [31:0] PC_M;
  logic        BD_M;
  logic        ERET_M;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        Interrupt;
  logic        ERET;
  logic [31:0] EPC;
  logic        flush;

  int checks = 0;
  int errors = 0;

  // Model: architectural CP0 contents plus "pulse due" flags and handler mode.
  logic [5:0]  m_im, m_ip;
  logic        m_ie, m_exl, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic        m_handler, m_int, m_eret;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .HWInt(HWInt), .ExcCode_M(ExcCode_M), .PC_M(PC_M),
    .BD_M(BD_M), .ERET_M(ERET_M), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .Interrupt(Interrupt),
    .ERET(ERET), .EPC(EPC), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return 32'h2019_0305;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_im = 0; m_ip = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_code = 0; m_epc = 0;
    m_handler = 0; m_int = 0; m_eret = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Interrupt"}, 32'(Interrupt), 32'(m_int));
    chk({tag, ".ERET"},      32'(ERET),      32'(m_eret));
    chk({tag, ".flush"},     32'(flush),     32'(m_int | m_eret));
    chk({tag, ".EPC"},       EPC,            m_epc);
    chk({tag, ".rdata"},     cp0_rdata,      m_read(cp0_addr));
  endtask

  // Advance one clock: predict from the rules, then compare just after the edge.
  task automatic step(input string tag);
    logic ireq, ereq, trap, ret;
    logic [5:0]  n_im;
    logic        n_ie, n_exl, n_bd, n_handler, n_int, n_eret;
    logic [4:0]  n_code;
    logic [31:0] n_epc;
    ireq = ((HWInt & m_im) != 0) && m_ie && !m_exl;
    ereq = (ExcCode_M != 0) && !m_exl;
    trap = 0; ret = 0;
    n_im = m_im; n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_code = m_code; n_epc = m_epc;
    n_handler = m_handler; n_int = 0; n_eret = 0;
    if (m_int) n_handler = 1;
    else if (m_eret) n_handler = 0;
    else if (!m_handler && (ireq || ereq)) trap = 1;
    else if (ERET_M) ret = 1;
    if (trap) begin
      n_int = 1; n_exl = 1; n_bd = BD_M;
      n_code = ireq ? 5'd0 : ExcCode_M;
      n_epc = (BD_M ? PC_M - 32'd4 : PC_M) & 32'hFFFF_FFFC;
    end else if (ret) begin
      n_eret = 1; n_exl = 0;
    end else if (cp0_we && cp0_addr == 5'd12) begin
      n_im = cp0_wdata[15:10]; n_exl = cp0_wdata[1]; n_ie = cp0_wdata[0];
    end else if (cp0_we && cp0_addr == 5'd14) begin
      n_epc = cp0_wdata & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
    m_ip = HWInt; m_im = n_im; m_ie = n_ie; m_exl = n_exl; m_bd = n_bd; m_code = n_code;
    m_epc = n_epc; m_handler = n_handler; m_int = n_int; m_eret = n_eret;
    check_all(tag);
  endtask

  task automatic idle();
    HWInt = 0; ExcCode_M = 0; ERET_M = 0; cp0_we = 0; BD_M = 0; PC_M = 0; cp0_wdata = 0;
  endtask

  initial begin
    idle();
    cp0_addr = 5'd12;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    cp0_addr = 5'd15;
    #1 chk("prid", cp0_rdata, 32'h2019_0305);
    @(posedge clk); #1 reset = 1'b0;
    cp0_addr = 5'd13;
    HWInt = 6'b111111;
    step("no_trap_after_reset");
    chk("no_trap_after_reset.int", 32'(Interrupt), 32'd0);

    // SR = IM all, IE; then a single interrupt line
    HWInt = 0; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
    step("mtc0_sr");
    cp0_we = 0; HWInt = 6'b000100; PC_M = 32'h0000_3010; cp0_addr = 5'd13;
    step("int_trap");
    chk("int_trap.int_const", 32'(Interrupt), 32'd1);
    chk("int_trap.epc_const", EPC, 32'h0000_3010);
    chk("int_trap.cause_const", cp0_rdata, 32'h0000_1000);
    cp0_addr = 5'd12;
    #1 chk("int_trap.sr_exl", cp0_rdata, 32'h0000_FC03);

    // Handler ignores a fully asserted interrupt bus until ERET
    HWInt = 6'b111111;
    step("handler1");
    step("handler2");
    step("handler3");
    ERET_M = 1;
    step("eret");
    chk("eret.pulse", 32'(ERET), 32'd1);
    chk("eret.sr", cp0_rdata, 32'h0000_FC01);
    ERET_M = 0;
    step("after_eret");
    step("pending_trap");
    chk("pending_trap.int", 32'(Interrupt), 32'd1);
    HWInt = 0;
    step("h_a"); ERET_M = 1; step("r_a"); ERET_M = 0; step("run_a");

    // Delay-slot exception
    ExcCode_M = 5'd12; BD_M = 1; PC_M = 32'h0000_3024; cp0_addr = 5'd13;
    step("exc_bd");
    chk("exc_bd.epc_const", EPC, 32'h0000_3020);
    chk("exc_bd.cause_const", cp0_rdata, 32'h8000_0030);
    idle(); step("h_b"); ERET_M = 1; step("r_b"); ERET_M = 0; step("run_b");

    // Interrupt beats a simultaneous exception
    HWInt = 6'b000100; ExcCode_M = 5'd4; PC_M = 32'h0000_3100;
    step("int_prio");
    chk("int_prio.cause", cp0_rdata, 32'h0000_1000);
    idle(); step("int_prio.single");
    chk("int_prio.single_int", 32'(Interrupt), 32'd0);
    ERET_M = 1; step("r_c"); ERET_M = 0; step("run_c");

    // SR write in the trapping cycle is lost
    ExcCode_M = 5'd8; PC_M = 32'h0000_3200; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
    step("lost_mtc0");
    chk("lost_mtc0.sr", cp0_rdata, 32'h0000_FC03);
    idle(); step("h_d"); ERET_M = 1; step("r_d"); ERET_M = 0; step("run_d");
    cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
    step("mtc0_epc");
    chk("mtc0_epc.read", cp0_rdata, 32'h0000_3004);
    cp0_we = 0;

    // EPC wrap-around
    ExcCode_M = 5'd10; BD_M = 1; PC_M = 32'h0;
    step("epc_wrap");
    chk("epc_wrap.epc", EPC, 32'hFFFF_FFFC);
    idle(); step("h_e"); ERET_M = 1; step("r_e"); ERET_M = 0; step("run_e");

    // Asynchronous reset in the middle of a trap pulse
    HWInt = 6'b000001; PC_M = 32'h0000_3300; cp0_addr = 5'd12;
    step("pre_reset_trap");
    chk("pre_reset_trap.int", 32'(Interrupt), 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset.flush", 32'(flush), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    step("post_reset1");
    step("post_reset2");
    chk("post_reset2.int", 32'(Interrupt), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      ExcCode_M = ($urandom_range(0, 6) == 0) ? 5'($urandom) : 5'd0;
      ERET_M    = ($urandom_range(0, 4) == 0);
      cp0_we    = ($urandom_range(0, 5) == 0);
      cp0_addr  = 5'(12 + $urandom_range(0, 4));
      cp0_wdata = $urandom;
      PC_M      = $urandom;
      BD_M      = 1'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port HWInt  input  6  external interrupt lines IP[7:2], level-sensitive.
REQ-004 SHALL have port ExcCode_M  input  5  exception code of the M-stage instruction; 0 = no exception.
REQ-005 SHALL have port PC_M  input  32  PC of the M-stage instruction.
REQ-006 SHALL have port BD_M  input  1  M-stage instruction sits in a branch delay slot.
REQ-007 SHALL have port ERET_M  input  1  ERET in M stage.
REQ-008 SHALL have port cp0_we  input  1  MTC0 write enable.
REQ-009 SHALL have port cp0_addr  input  5  CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId).
REQ-010 SHALL have port cp0_wdata  input  32  MTC0 data.
REQ-011 SHALL have port cp0_rdata  output  32  MFC0 data, combinational on cp0_addr.
REQ-012 SHALL have port Interrupt  output  1  one-cycle redirect request to next-PC logic (target 0x00004180).
REQ-013 SHALL have port ERET  output  1  one-cycle return request to next-PC logic (target EPC).
REQ-014 SHALL have port EPC  output  32  current EPC register value.
REQ-015 SHALL have port flush  output  1  flush F/D/E pipeline registers; high whenever Interrupt or ERET is high.

Function
REQ-016 SHALL hold registers SR {IM[15:10], EXL[1], IE[0]}, Cause {BD[31], IP[15:10], ExcCode[6:2]}, EPC[31:0]; PRId reads constant 0x20190305; unlisted bits read 0.
REQ-017 SHALL sample HWInt into Cause.IP every cycle regardless of state.
REQ-018 SHALL compute IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL and ExcReq = (ExcCode_M != 0) & ~SR.EXL.
REQ-019 SHALL implement FSM states RUN, TRAP, HANDLER, RETURN.
REQ-020 RUN: on IntReq or ExcReq -> TRAP; else on ERET_M -> RETURN; else stay.
REQ-021 TRAP (exactly 1 cycle): Interrupt=1, flush=1; next state HANDLER.
REQ-022 On the RUN->TRAP edge SHALL set SR.EXL=1, Cause.BD=BD_M, Cause.ExcCode = IntReq ? 0 : ExcCode_M, EPC = (BD_M ? PC_M-4 : PC_M) with bits[1:0] forced 0.
REQ-023 Interrupt SHALL take priority over a simultaneous synchronous exception (ExcCode recorded as 0).
REQ-024 HANDLER: no traps (EXL=1); on ERET_M -> RETURN; else stay.
REQ-025 RETURN (exactly 1 cycle): ERET=1, flush=1, EPC output stable; SR.EXL cleared on RUN/HANDLER->RETURN edge; next state RUN.
REQ-026 ERET_M in RUN (EXL=0) SHALL still be honored (RETURN); trap request in the same cycle SHALL win over ERET_M.
REQ-027 MTC0 SHALL write SR (IM, EXL, IE only) or EPC (bits[1:0] forced 0); Cause and PRId SHALL be read-only.
REQ-028 MTC0 in a cycle where FSM leaves RUN or HANDLER for TRAP/RETURN SHALL be discarded (instruction flushed/superseded).
REQ-029 Interrupt and ERET SHALL never be high in the same cycle; each SHALL be registered (Moore outputs of TRAP/RETURN).
REQ-030 EPC arithmetic SHALL be 32-bit modulo (PC_M=0 with BD_M=1 yields 0xFFFFFFFC).

Reset
REQ-031 On reset assertion, SHALL immediately force state RUN, SR=0, Cause=0, EPC=0, Interrupt=0, ERET=0, flush=0, regardless of clk.
REQ-032 Reset mid-TRAP or mid-RETURN SHALL abort the pulse in the same cycle; no redirect after release.
REQ-033 First trap after release SHALL require IE and IM to be set by MTC0.

Verification
REQ-034 MTC0 SR=0x0000FC01, HWInt=6'b000100, PC_M=0x00003010, BD_M=0 -> next cycle Interrupt=1, flush=1, EPC=0x00003010, Cause=0x00001000, SR.EXL=1; then HANDLER.
REQ-035 EXL=0, ExcCode_M=12, BD_M=1, PC_M=0x00003024 -> TRAP, EPC=0x00003020, Cause=0x80000030.
REQ-036 In HANDLER, HWInt=6'b111111 held -> no Interrupt pulse; ERET_M=1 -> ERET=1 one cycle, EXL=0, then pending interrupt traps next cycle.
REQ-037 HWInt and ExcCode_M=4 same cycle, SR=0x0000FC01 -> Cause.ExcCode=0, single Interrupt pulse.
REQ-038 cp0_we=1 to SR in trap cycle -> SR write lost, EXL=1; MTC0 EPC=0x00003007 -> EPC reads 0x00003004.
REQ-039 Assert reset asynchronously during TRAP -> Interrupt/flush drop before next clk edge, all registers 0.
